// File: rtl/cla_pkg.sv
// Shared constants, state encoding and sizing helper for the serial nibble adder/subtractor.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_nibble_comb.sv
// Purely combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla_nibble_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g, p;
  logic       c1, c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms: every carry depends only on g/p and ci.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_sub.sv
// WIDTH-bit add/sub that reuses one 4-bit CLA slice, one nibble per cycle, LSB first.
// Define CLA_SUB_OVFL_EN to add the signed-overflow output ovfl.
module cla_serial_sub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef CLA_SUB_OVFL_EN
  ,
  output logic             ovfl
`endif
);

  localparam int NIB   = nibbles(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state;
  logic [WIDTH-1:0]   opa, opb;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [NIB_W-1:0]   nib_s;
  logic               nib_co;
`ifdef CLA_SUB_OVFL_EN
  logic               nib_c3;
`else
  logic               nib_c3_unused;
`endif

  // Operands shift right each RUN cycle so the slice always sees the low nibble.
  cla_nibble_comb u_nib (
    .a  (opa[NIB_W-1:0]),
    .b  (opb[NIB_W-1:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
`ifdef CLA_SUB_OVFL_EN
    .c3 (nib_c3)
`else
    .c3 (nib_c3_unused)
`endif
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef CLA_SUB_OVFL_EN
      ovfl   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[NIB_W*idx +: NIB_W] <= nib_s;
          opa   <= opa >> NIB_W;
          opb   <= opb >> NIB_W;
          carry <= nib_co;
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(NIB - 1)) begin
            cout  <= nib_co;
`ifdef CLA_SUB_OVFL_EN
            ovfl  <= nib_c3 ^ nib_co;
`endif
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_sub.sv
// Directed bench for cla_serial_sub (WIDTH=16) with an arithmetic reference model and scoreboard.
module tb_cla_serial_sub;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, sub, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, result;
`ifdef CLA_SUB_OVFL_EN
  logic         ovfl;
`endif

  cla_serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef CLA_SUB_OVFL_EN
    ,
    .ovfl      (ovfl)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int npop  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  // Reference: plain integer arithmetic, no carry-chain modelling.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic mc);
    exp_t e;
    int   sa, sb, d;
    longint u;
    sa = $signed(ma);
    sb = $signed(mb);
    if (ms) begin
      u    = longint'(ma) - longint'(mb);
      e.co = (ma >= mb);
      d    = sa - sb;
    end else begin
      u    = longint'(ma) + longint'(mb) + longint'(mc);
      e.co = (u >= (64'sd1 <<< W));
      d    = sa + sb + int'(mc);
    end
    e.res = u[W-1:0];
    e.ov  = (d > 32767) || (d < -32768);
    return e;
  endfunction

  exp_t exp_q[$];

  // Scoreboard: record accepted operands, check every delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
      if (out_valid && out_ready) begin
        npop++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_cout", cout, e.co);
`ifdef CLA_SUB_OVFL_EN
          chk("sb_ovfl", ovfl, e.ov);
`endif
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic tc, input int hold, output logic [W-1:0] r,
                        output logic co, output logic ov, output int lat);
    int n;
    r = '0; co = 1'b0; ov = 1'b0; lat = 0;
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin chk("op_wait_ready_timeout", 32'd1, 32'd0); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) begin chk("op_wait_valid_timeout", 32'd1, 32'd0); return; end
    r  = result;
    co = cout;
`ifdef CLA_SUB_OVFL_EN
    ov = ovfl;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_result_stable", result, r);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_out_valid", out_valid, 1'b0);
  endtask

  logic [W-1:0] r;
  logic         co, ov;
  int           lat;

  logic [W-1:0] va[3] = '{16'h1234, 16'hFFFF, 16'h8000};
  logic [W-1:0] vb[3] = '{16'h0FED, 16'h0001, 16'h8000};
  logic         vs[3] = '{1'b0, 1'b1, 1'b0};
  logic         vc[3] = '{1'b1, 1'b0, 1'b0};
  int           acc[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n, p0;
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    reset = 1'b1;

    // edges from accept to out_valid = WIDTH/4 (5th cycle counting the accept cycle)
    run_op(16'h000D, 16'h0007, 1'b1, 1'b0, 0, r, co, ov, lat);
    chk("t1_result", r, 16'h0006);
    chk("t1_cout", co, 1'b1);
    chk("t1_latency", lat, NIB);

    run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 0, r, co, ov, lat);
    chk("t2_result", r, 16'hFFFF);
    chk("t2_cout", co, 1'b0);
`ifdef CLA_SUB_OVFL_EN
    chk("t2_ovfl", ov, 1'b0);
`endif

    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, r, co, ov, lat);
    chk("t3_add_result", r, 16'h0000);
    chk("t3_add_cout", co, 1'b1);

    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, r, co, ov, lat);
    chk("t3_sub_result", r, 16'h7FFF);
    chk("t3_sub_cout", co, 1'b1);
`ifdef CLA_SUB_OVFL_EN
    chk("t3_sub_ovfl", ov, 1'b1);
`endif

    run_op(16'hA5C3, 16'hA5C3, 1'b1, 1'b0, 0, r, co, ov, lat);
    chk("eq_result", r, 16'h0000);
    chk("eq_cout", co, 1'b1);

    // back-pressure for 10 cycles
    run_op(16'h3C5A, 16'h1111, 1'b0, 1'b0, 10, r, co, ov, lat);
    chk("t4_result", r, 16'h4D6B);
    chk("t4_cout", co, 1'b0);

    // reset during the 2nd RUN cycle
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_result", result, 16'h0000);
    reset = 1'b1;
    exp_q.delete();
    run_op(16'h1000, 16'h0FFF, 1'b1, 1'b0, 0, r, co, ov, lat);
    chk("t5_fresh_result", r, 16'h0001);
    chk("t5_fresh_cout", co, 1'b1);

    // back-to-back with in_valid held high, operands scrambled mid-RUN
    out_ready = 1'b1;
    in_valid  = 1'b1;
    p0 = npop;
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k]; sub = vs[k]; cin = vc[k];
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("b2b_ready_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      acc[k] = cyc;
      a = 16'hDEAD; b = 16'hBEEF; sub = ~sub; cin = ~cin;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (npop < p0 + 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_count", npop - p0, 3);
    chk("b2b_space01", (acc[1] - acc[0]) >= NIB + 2, 1'b1);
    chk("b2b_space12", (acc[2] - acc[1]) >= NIB + 2, 1'b1);
    out_ready = 1'b0;
    chk("b2b_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
